// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and queues {pc, inst} pairs for ID.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_fetch_queue #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  input  logic        id_ready_i
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] if_fetch_cnt_o,
  output logic [31:0] if_stall_cnt_o
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e state_q, state_d;

  logic [31:0]     pc_q, pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];

  logic push;
  logic pop;
  logic pop_eff;

  // Redirect targets are word aligned; the low bits are intentionally dropped.
  logic unused_target_lsb;
  assign unused_target_lsb = ^branch_target_addr_i[1:0];

  // FSM: IDLE only directly after reset, RUN forever after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rom_ce_o = 1'b0;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        state_d  = StRun;
        rom_ce_o = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rom_addr_o = pc_q;

  assign id_valid_o = (count_q != '0);
  assign pop        = id_valid_o & id_ready_i;
  // A redirect discards the queue, so a coincident handshake does not retire anything.
  assign pop_eff    = pop & ~branch_flag_i;
  assign push       = rom_ce_o & ~branch_flag_i & ((count_q < FullCnt) | pop);

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (branch_flag_i) begin
      pc_d     = {branch_target_addr_i[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CntW'(push) - CntW'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= rom_inst_i;
    end
  end

  assign id_pc_o   = id_valid_o ? pc_mem[rd_ptr_q]   : 32'h0000_0000;
  assign id_inst_o = id_valid_o ? inst_mem[rd_ptr_q] : 32'h0000_0000;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop_eff) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if ((state_q == StRun) && !push && !branch_flag_i) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign if_fetch_cnt_o = fetch_cnt_q;
  assign if_stall_cnt_o = stall_cnt_q;
`endif

  a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= FullCnt);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: scoreboard of expected {pc, inst} deliveries plus
// directed checks on reset, stall, branch, wrap and (with IF_PERF_CNT_EN) the counters.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_pops   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_target;

  always #5 clk = ~clk;

  // ROM model: word content is its address scrambled with a fixed pattern.
  assign rom_inst = rom_addr ^ 32'hA5A5_A5A5;

  if_fetch_queue #(
    .FIFO_DEPTH(2),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .branch_flag_i       (branch_flag),
    .branch_target_addr_i(branch_target),
    .rom_ce_o            (rom_ce),
    .rom_addr_o          (rom_addr),
    .rom_inst_i          (rom_inst),
    .id_valid_o          (id_valid),
    .id_pc_o             (id_pc),
    .id_inst_o           (id_inst),
    .id_ready_i          (id_ready)
`ifdef IF_PERF_CNT_EN
    ,
    .if_fetch_cnt_o      (fetch_cnt),
    .if_stall_cnt_o      (stall_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // A handshake retires the head only when no reset or redirect overrides it.
  task automatic sb_sample();
    logic [31:0] e;
    if (!rst && !branch_flag && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_has_expect", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_pc", id_pc, e);
        check_eq("sb_inst", id_inst, e ^ 32'hA5A5_A5A5);
      end
      n_pops++;
    end
  endtask

  // Samples on the falling edge, returns 1 time unit after the next rising edge.
  task automatic cycle();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
    id_ready      = 1'b0;
    repeat (3) cycle();
    check_eq("rst_ce", 32'(rom_ce), 32'd0);
    check_eq("rst_valid", 32'(id_valid), 32'd0);
    check_eq("rst_pc", id_pc, 32'h0);
    check_eq("rst_inst", id_inst, 32'h0);
    check_eq("rst_addr", rom_addr, 32'h0);

    // Streaming with ready held high.
    rst      = 1'b0;
    id_ready = 1'b1;
    sb_load(32'h0, 64);
    n_pops = 0;
    cycle();
    check_eq("t1_ce", 32'(rom_ce), 32'd1);
    check_eq("t1_valid_early", 32'(id_valid), 32'd0);
    check_eq("t1_addr_hold", rom_addr, 32'h0);
    cycle();
    check_eq("t1_valid", 32'(id_valid), 32'd1);
    check_eq("t1_first_pc", id_pc, 32'h0);
    check_eq("t1_first_inst", id_inst, 32'hA5A5_A5A5);
    repeat (8) cycle();
    check_eq("t1_pops", n_pops, 32'd8);
    check_eq("t1_head", id_pc, 32'h20);

    // Stall with ID not ready: queue fills with 0,4 and the PC parks at 8.
    rst      = 1'b1;
    id_ready = 1'b0;
    cycle();
    rst = 1'b0;
    sb_load(32'h0, 64);
    n_pops = 0;
    repeat (7) cycle();
    check_eq("t2_addr", rom_addr, 32'h8);
    check_eq("t2_valid", 32'(id_valid), 32'd1);
    check_eq("t2_head", id_pc, 32'h0);
    check_eq("t2_pops", n_pops, 32'd0);

    // Full queue with a pop every cycle: push and pop coincide.
    id_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check_eq("t3_addr", rom_addr, 32'(8 + 4 * i));
      check_eq("t3_head", id_pc, 32'(4 * i));
    end

    // Redirect while two entries are queued; stale entries must never appear.
    branch_flag   = 1'b1;
    branch_target = 32'h0000_0103;
    sb_load(32'h100, 64);
    cycle();
    check_eq("t4_valid", 32'(id_valid), 32'd0);
    check_eq("t4_addr", rom_addr, 32'h100);
    branch_flag = 1'b0;
    cycle();
    check_eq("t4_first_pc", id_pc, 32'h100);
    repeat (4) cycle();

    // Redirect held for several cycles with a moving target.
    branch_flag = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_target = 32'h200 + 32'(16 * i);
      last_target   = branch_target;
      cycle();
      check_eq("t4h_addr", rom_addr, last_target);
      check_eq("t4h_valid", 32'(id_valid), 32'd0);
    end
    sb_load(last_target, 64);
    branch_flag = 1'b0;
    repeat (3) cycle();
    check_eq("t4h_head", id_pc, last_target + 32'd8);

    // PC wrap across the top of the address space.
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    sb_load(32'hFFFF_FFF8, 64);
    cycle();
    branch_flag = 1'b0;
    repeat (6) cycle();
    check_eq("wrap_addr", rom_addr, 32'h10);
    check_eq("wrap_head", id_pc, 32'hC);

    // Single-cycle reset mid-stream with one entry queued.
    rst = 1'b1;
    cycle();
    check_eq("t5_ce", 32'(rom_ce), 32'd0);
    check_eq("t5_valid", 32'(id_valid), 32'd0);
    check_eq("t5_pc", id_pc, 32'h0);
    check_eq("t5_inst", id_inst, 32'h0);
    check_eq("t5_addr", rom_addr, 32'h0);
    rst = 1'b0;
    sb_load(32'h0, 64);
    cycle();
    check_eq("t5_ce_up", 32'(rom_ce), 32'd1);
    cycle();
    check_eq("t5_valid_up", 32'(id_valid), 32'd1);
    check_eq("t5_first_pc", id_pc, 32'h0);
    repeat (3) cycle();

`ifdef IF_PERF_CNT_EN
    rst      = 1'b1;
    id_ready = 1'b0;
    cycle();
    check_eq("t6_fetch_rst", fetch_cnt, 32'd0);
    check_eq("t6_stall_rst", stall_cnt, 32'd0);
    rst = 1'b0;
    sb_load(32'h0, 64);
    repeat (6) cycle();
    check_eq("t6_stall3", stall_cnt, 32'd3);
    check_eq("t6_fetch0", fetch_cnt, 32'd0);
    id_ready = 1'b1;
    repeat (10) cycle();
    check_eq("t6_fetch10", fetch_cnt, 32'd10);
    check_eq("t6_stall_keep", stall_cnt, 32'd3);
    id_ready      = 1'b0;
    branch_flag   = 1'b1;
    branch_target = 32'h40;
    sb_load(32'h40, 64);
    cycle();
    branch_flag = 1'b0;
    check_eq("t6_fetch_br", fetch_cnt, 32'd10);
    check_eq("t6_stall_br", stall_cnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage between the PC logic and the decode stage.
- Owns the program counter and drives the instruction ROM's chip-enable and byte address.
- Captures each returned word together with its PC into a small FIFO.
- Presents the FIFO head to ID over a valid/ready handshake.
- Branch redirects from ID/EX flush the queue and reload the PC.

Parameters:
- FIFO_DEPTH, 2, queue entries; power of two, legal range 2..8.
- RESET_PC, 32'h00000000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- branch_flag_i  in  1  redirect request; takes effect at the next edge.
- branch_target_addr_i  in  32  redirect byte address.
- rom_ce_o  out  1  ROM chip-enable; registered.
- rom_addr_o  out  32  ROM byte address; equals the current PC.
- rom_inst_i  in  32  ROM data; combinational, valid in the same cycle as rom_addr_o; already byte-ordered.
- id_valid_o  out  1  FIFO head is valid.
- id_pc_o  out  32  PC of the head entry.
- id_inst_o  out  32  instruction of the head entry.
- id_ready_i  in  1  ID accepts the head this cycle.

Behaviour:
Interface:
- One clock (clk). Reset rst is synchronous and active-high.

Reset, evaluated at the edge while rst=1:
- pc = RESET_PC.
- rom_ce_o = 0.
- FIFO cleared: count 0, pointers 0.
- id_valid_o = 0; id_pc_o = 0; id_inst_o = 32'h00000000 (NOP).
- rst=1 mid-operation discards all in-flight state identically.

After reset:
- The first edge with rst=0 sets rom_ce_o=1.
- rom_ce_o then stays 1 until the next reset.
- The first capture happens at the second edge after rst falls.

Definitions:
- pop = id_valid_o & id_ready_i.
- push = rom_ce_o & ~branch_flag_i & (count < FIFO_DEPTH | pop).

Per-edge priority:
1. rst.
2. branch_flag_i:
   - FIFO flushed (count 0), pop ignored.
   - pc = {branch_target_addr_i[31:2], 2'b00}.
   - No capture.
3. Normal operation:
   - If push: write {pc, rom_inst_i} at the write pointer and set pc = pc + 4.
   - If pop: advance the read pointer.
   - count updates by push - pop.

Boundary rules:
- Full (count == FIFO_DEPTH) with no pop: pc holds, no capture, rom_addr_o is stable.
- Full with pop in the same cycle: push is allowed and count stays at FIFO_DEPTH.
- Empty: id_valid_o=0, id_pc_o=0, id_inst_o=0.
- Push into an empty FIFO: the entry is visible on id_* in the following cycle. Minimum ROM-to-ID latency is 1 cycle; no same-cycle bypass.
- Pointers wrap modulo FIFO_DEPTH.
- pc arithmetic is 32-bit; 32'hFFFFFFFC + 4 wraps to 0.
- id_* outputs are driven from FIFO storage (head entry) and masked when empty; no combinational path from rom_inst_i or id_ready_i to id_*.
- Branch asserted while the FIFO is empty or full: same flush/reload rule applies.
- Branch held for several cycles: pc is reloaded each cycle and nothing is captured.

State machine: two states.
- IDLE: rom_ce_o=0; entered on reset.
- RUN: rom_ce_o=1.
- Transition IDLE→RUN on the first edge with rst=0.
- RUN→IDLE only on rst.

Optional Feature:
Macro: IF_PERF_CNT_EN.

Defined:
- Adds output if_fetch_cnt_o [31:0]: increments on every pop.
- Adds output if_stall_cnt_o [31:0]: increments every RUN cycle in which push=0 and branch_flag_i=0.
- Both counters reset to 0 on rst, are not cleared by branch, and wrap at 2^32.

Undefined:
- Neither port nor the counter logic exists.
- All other behaviour is identical.

Test Plan:
1. Reset release, id_ready_i=1, ROM word = addr^32'hA5A5A5A5 → rom_ce_o rises one cycle after rst falls. ID then sees PC 0,4,8,... one per cycle with inst 32'hA5A5A5A5, 32'hA5A5A5A1, ...
2. id_ready_i=0 for 6 cycles with FIFO_DEPTH=2 → exactly 2 entries captured (PC 0,4). rom_addr_o stays 8. Releasing ready yields 0,4,8 with no duplicates or gaps.
3. Full FIFO with pop every cycle → push and pop coincide, count stays 2, PC advances by 4 per cycle.
4. branch_flag_i=1, target 32'h00000103, while 2 entries are queued → next cycle id_valid_o=0 and rom_addr_o=32'h00000100. The first delivered PC is 32'h100; the stale entries are never delivered.
5. rst pulsed for one cycle mid-stream with 1 entry queued → all outputs return to reset values, and fetch restarts at RESET_PC.
6. With IF_PERF_CNT_EN, 10 pops and 3 full-stall cycles → if_fetch_cnt_o=10, if_stall_cnt_o=3. After a branch the counters are unchanged.
